// File: rtl/window_generator_3x3_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : window_generator_3x3_if                                      |
// | Description : Pixel stream in / registered 3x3 window out bundle.          |
// | Macro       : WINDOW_SOF_EN adds the sof qualifier on the input stream.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

interface window_generator_3x3_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  pixel_valid;
`ifdef WINDOW_SOF_EN
  logic                  sof;
`endif
  logic [DATA_WIDTH-1:0] pixel0;
  logic [DATA_WIDTH-1:0] pixel1;
  logic [DATA_WIDTH-1:0] pixel2;
  logic [DATA_WIDTH-1:0] pixel3;
  logic [DATA_WIDTH-1:0] pixel4;
  logic [DATA_WIDTH-1:0] pixel5;
  logic [DATA_WIDTH-1:0] pixel6;
  logic [DATA_WIDTH-1:0] pixel7;
  logic [DATA_WIDTH-1:0] pixel8;
  logic                  window_valid;

`ifdef WINDOW_SOF_EN
  modport master (
    output pixel_in, pixel_valid, sof,
    input  pixel0, pixel1, pixel2, pixel3, pixel4,
           pixel5, pixel6, pixel7, pixel8, window_valid
  );
  modport slave (
    input  pixel_in, pixel_valid, sof,
    output pixel0, pixel1, pixel2, pixel3, pixel4,
           pixel5, pixel6, pixel7, pixel8, window_valid
  );
`else
  modport master (
    output pixel_in, pixel_valid,
    input  pixel0, pixel1, pixel2, pixel3, pixel4,
           pixel5, pixel6, pixel7, pixel8, window_valid
  );
  modport slave (
    input  pixel_in, pixel_valid,
    output pixel0, pixel1, pixel2, pixel3, pixel4,
           pixel5, pixel6, pixel7, pixel8, window_valid
  );
`endif

endinterface

`default_nettype wire

// File: rtl/window_generator_3x3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : window_generator_3x3                                         |
// | Description : Raster pixel stream to registered 3x3 window, two line       |
// |               buffers, one-cycle latency.                                  |
// | Macro       : WINDOW_SOF_EN adds sof to force frame alignment.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module window_generator_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  wire                    clk,
  input  wire                    rst,
  window_generator_3x3_if.slave  bus
);

  localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 2;
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 2;
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] C_COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] C_ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_eff;
  logic [ROW_W-1:0] row_eff;
  logic             accept;
  logic             window_hit;

  // Line buffers: mid holds row r-1, top holds row r-2 (no reset needed).
  logic [DATA_WIDTH-1:0] line_mid_q [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] line_top_q [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] top_cur;
  logic [DATA_WIDTH-1:0] mid_cur;

  // Previous two columns of each of the three window rows.
  logic [DATA_WIDTH-1:0] top_m1_q, top_m1_d, top_m2_q, top_m2_d;
  logic [DATA_WIDTH-1:0] mid_m1_q, mid_m1_d, mid_m2_q, mid_m2_d;
  logic [DATA_WIDTH-1:0] bot_m1_q, bot_m1_d, bot_m2_q, bot_m2_d;

  logic [DATA_WIDTH-1:0] win_q [0:8];
  logic [DATA_WIDTH-1:0] win_d [0:8];
  logic                  window_valid_q, window_valid_d;

  assign accept = bus.pixel_valid;

`ifdef WINDOW_SOF_EN
  assign col_eff = bus.sof ? '0 : col_q;
  assign row_eff = bus.sof ? '0 : row_q;
`else
  assign col_eff = col_q;
  assign row_eff = row_q;
`endif

  assign top_cur    = line_top_q[col_eff];
  assign mid_cur    = line_mid_q[col_eff];
  assign window_hit = accept && (row_eff >= C_ROW_TWO) && (col_eff >= C_COL_TWO);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_eff == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == C_ROW_LAST) ? '0 : row_eff + ROW_W'(1);
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
      end
    end
  end

  always_comb begin
    top_m1_d = top_m1_q;
    top_m2_d = top_m2_q;
    mid_m1_d = mid_m1_q;
    mid_m2_d = mid_m2_q;
    bot_m1_d = bot_m1_q;
    bot_m2_d = bot_m2_q;
    if (accept) begin
      top_m2_d = top_m1_q;
      top_m1_d = top_cur;
      mid_m2_d = mid_m1_q;
      mid_m1_d = mid_cur;
      bot_m2_d = bot_m1_q;
      bot_m1_d = bus.pixel_in;
    end
  end

  always_comb begin
    win_d          = win_q;
    window_valid_d = 1'b0;
    if (window_hit) begin
      win_d[0]       = top_m2_q;
      win_d[1]       = top_m1_q;
      win_d[2]       = top_cur;
      win_d[3]       = mid_m2_q;
      win_d[4]       = mid_m1_q;
      win_d[5]       = mid_cur;
      win_d[6]       = bot_m2_q;
      win_d[7]       = bot_m1_q;
      win_d[8]       = bus.pixel_in;
      window_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      top_m1_q       <= '0;
      top_m2_q       <= '0;
      mid_m1_q       <= '0;
      mid_m2_q       <= '0;
      bot_m1_q       <= '0;
      bot_m2_q       <= '0;
      window_valid_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      top_m1_q       <= top_m1_d;
      top_m2_q       <= top_m2_d;
      mid_m1_q       <= mid_m1_d;
      mid_m2_q       <= mid_m2_d;
      bot_m1_q       <= bot_m1_d;
      bot_m2_q       <= bot_m2_d;
      window_valid_q <= window_valid_d;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  // Each accepted pixel ages its column down one row: mid -> top, input -> mid.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_top_q[col_eff] <= mid_cur;
      line_mid_q[col_eff] <= bus.pixel_in;
    end
  end

  assign bus.pixel0       = win_q[0];
  assign bus.pixel1       = win_q[1];
  assign bus.pixel2       = win_q[2];
  assign bus.pixel3       = win_q[3];
  assign bus.pixel4       = win_q[4];
  assign bus.pixel5       = win_q[5];
  assign bus.pixel6       = win_q[6];
  assign bus.pixel7       = win_q[7];
  assign bus.pixel8       = win_q[8];
  assign bus.window_valid = window_valid_q;

endmodule

`default_nettype wire
